// File: rtl/pwm_pkg.sv
// Shared definitions for the dead-time PWM gate driver.
//   DT_W_DEFAULT : default width of the dead_time input
//   pwm_state_e  : gate-driver FSM states
//   pwm_drive_t  : registered output bundle (hi, lo, dead, short_pulse)
//   drive_for()  : output decode for a given state
package pwm_pkg;

    localparam int DT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        OFF,
        LO_ON,
        DT_RISE,
        HI_ON,
        DT_FALL
    } pwm_state_e;

    typedef struct packed {
        logic hi;
        logic lo;
        logic dead;
        logic short_pulse;
    } pwm_drive_t;

    // Each gate is on in exactly one state, so hi and lo are never
    // decoded high together.
    function automatic pwm_drive_t drive_for(pwm_state_e s, logic short_flag);
        pwm_drive_t d;
        d.hi          = (s == HI_ON);
        d.lo          = (s == LO_ON);
        d.dead        = (s == DT_RISE) || (s == DT_FALL);
        d.short_pulse = short_flag;
        return d;
    endfunction

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter that times the dead interval.
//   clk, reset : clock, synchronous active-high reset (clears value)
//   load       : load load_val (priority over dec)
//   load_val   : interval length, already clamped to >= 1 by the caller
//   dec        : decrement by one
//   value      : current count
//   expire     : value == 1, i.e. this is the last dead cycle
module pwm_dt_counter #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    input  logic            dec,
    output logic [DT_W-1:0] value,
    output logic            expire
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            // The zero guard keeps a stray dec from wrapping to all-ones.
            value <= value - DT_W'(1);
        end
    end

    assign expire = (value == DT_W'(1));

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary gate driver with programmable dead time.
//   clk, reset  : single clock, synchronous active-high reset
//   enable      : 0 forces both gates off on the next edge
//   pwm_in      : upstream PWM (same clock domain)
//   dead_time   : dead interval in cycles, 0 behaves as 1; latched per interval
//   pwm_hi      : high-side gate drive (registered)
//   pwm_lo      : low-side gate drive (registered)
//   dead_active : high during a dead interval (registered)
//   short_pulse : one-cycle flag when pwm_in reverted before the interval ended
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic            dead_active,
    output logic            short_pulse
);

    pwm_state_e      state, state_n;
    pwm_drive_t      drv_q;
    logic            short_n;
    logic            cnt_load, cnt_dec, cnt_expire;
    logic [DT_W-1:0] cnt_value;
    logic [DT_W-1:0] dt_load;

    assign dt_load = (dead_time == '0) ? DT_W'(1) : dead_time;

    pwm_dt_counter #(.DT_W(DT_W)) u_dt_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (dt_load),
        .dec      (cnt_dec),
        .value    (cnt_value),
        .expire   (cnt_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OFF;
            drv_q <= '0;
        end else begin
            state <= state_n;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state and never pass through combinational logic.
            drv_q <= drive_for(state_n, short_n);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        short_n  = 1'b0;
        if (!enable) begin
            state_n = OFF;
        end else begin
            case (state)
                OFF: begin
                    // Leaving OFF into the high side still needs a full dead
                    // interval; the low side can be driven straight away.
                    if (pwm_in) begin
                        state_n  = DT_RISE;
                        cnt_load = 1'b1;
                    end else begin
                        state_n = LO_ON;
                    end
                end
                LO_ON: begin
                    if (pwm_in) begin
                        state_n  = DT_RISE;
                        cnt_load = 1'b1;
                    end
                end
                HI_ON: begin
                    if (!pwm_in) begin
                        state_n  = DT_FALL;
                        cnt_load = 1'b1;
                    end
                end
                DT_RISE: begin
                    // A reversal wins over expiry: the side we came from is
                    // re-driven and the aborted transition is flagged.
                    if (!pwm_in) begin
                        state_n = LO_ON;
                        short_n = 1'b1;
                    end else if (cnt_expire) begin
                        state_n = HI_ON;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                DT_FALL: begin
                    if (pwm_in) begin
                        state_n = HI_ON;
                        short_n = 1'b1;
                    end else if (cnt_expire) begin
                        state_n = LO_ON;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_n = OFF;
            endcase
        end
    end

    assign pwm_hi      = drv_q.hi;
    assign pwm_lo      = drv_q.lo;
    assign dead_active = drv_q.dead;
    assign short_pulse = drv_q.short_pulse;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Scoreboard bench for pwm_deadtime_gen: the stimulus process predicts the
// outputs after each edge and queues them; a negedge monitor compares.
module tb_pwm_deadtime_gen;

    localparam int DT_W = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            pwm_in;
    logic [DT_W-1:0] dead_time;
    logic            pwm_hi, pwm_lo, dead_active, short_pulse;

    pwm_deadtime_gen #(.DT_W(DT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .dead_time   (dead_time),
        .pwm_hi      (pwm_hi),
        .pwm_lo      (pwm_lo),
        .dead_active (dead_active),
        .short_pulse (short_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hi;
        bit lo;
        bit dead;
        bit sp;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: which gate is committed, and for a pending change
    // the side being moved to and how many dead cycles remain.
    typedef enum int {M_OFF, M_LO, M_HI, M_DEAD} mode_t;
    mode_t m_mode   = M_OFF;
    bit    m_target = 1'b0;
    int    m_left   = 0;

    function automatic exp_t model_edge(bit rst, bit en, bit pin, int dt);
        exp_t e;
        e.sp = 1'b0;
        if (rst) begin
            m_mode = M_OFF;
            m_left = 0;
        end else if (!en) begin
            m_mode = M_OFF;
        end else if (m_mode == M_DEAD) begin
            if (pin != m_target) begin
                m_mode = m_target ? M_LO : M_HI;
                e.sp   = 1'b1;
            end else if (m_left == 1) begin
                m_mode = m_target ? M_HI : M_LO;
            end else begin
                m_left = m_left - 1;
            end
        end else if (m_mode == M_OFF && !pin) begin
            m_mode = M_LO;
        end else if ((pin && m_mode != M_HI) || (!pin && m_mode != M_LO)) begin
            m_mode   = M_DEAD;
            m_target = pin;
            m_left   = (dt == 0) ? 1 : dt;
        end
        e.hi   = (m_mode == M_HI);
        e.lo   = (m_mode == M_LO);
        e.dead = (m_mode == M_DEAD);
        e.cyc  = cyc;
        return e;
    endfunction

    // Per-segment tallies of observed outputs, compared against values
    // worked out by hand from the timing rules.
    int dead_cnt, sp_cnt, hi_cnt;

    task automatic step(input bit rst, input bit en, input bit pin, input int dt);
        reset     = rst;
        enable    = en;
        pwm_in    = pin;
        dead_time = DT_W'(dt);
        exp_q.push_back(model_edge(rst, en, pin, dt));
        @(posedge clk);
        #1;
        cyc++;
        if (dead_active) dead_cnt++;
        if (short_pulse) sp_cnt++;
        if (pwm_hi)      hi_cnt++;
    endtask

    task automatic steps(input int n, input bit rst, input bit en, input bit pin, input int dt);
        for (int i = 0; i < n; i++) step(rst, en, pin, dt);
    endtask

    task automatic clr();
        dead_cnt = 0;
        sp_cnt   = 0;
        hi_cnt   = 0;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (pwm_hi && pwm_lo) begin
            n_fail++;
            $display("FAIL overlap: pwm_hi and pwm_lo both high at cycle %0d", cyc);
        end
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (pwm_hi !== e.hi || pwm_lo !== e.lo || dead_active !== e.dead ||
                short_pulse !== e.sp) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got hi=%b lo=%b dead=%b sp=%b, expected hi=%b lo=%b dead=%b sp=%b",
                         e.cyc, pwm_hi, pwm_lo, dead_active, short_pulse,
                         e.hi, e.lo, e.dead, e.sp);
            end
        end
    end

    initial begin
        bit       pin;
        bit [7:0] up_cnt;
        clr();

        // Reset state.
        steps(3, 1, 0, 0, 0);
        check("reset_hi", pwm_hi, 0);
        check("reset_lo", pwm_lo, 0);
        check("reset_dead", dead_active, 0);

        // D=3 rising edge: exactly 3 dead cycles, then high side.
        steps(4, 0, 1, 0, 3);
        check("lo_on_after_off", pwm_lo, 1);
        clr();
        steps(8, 0, 1, 1, 3);
        check("d3_dead_cycles", dead_cnt, 3);
        check("d3_hi_on", pwm_hi, 1);

        // dead_time=0 behaves as one dead cycle per transition.
        clr();
        pin = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pin = ~pin;
            steps(4, 0, 1, pin, 0);
        end
        check("d0_dead_cycles", dead_cnt, 6);

        // D=5, pwm_in high for only 2 cycles: aborted rise.
        steps(8, 0, 1, 0, 5);
        clr();
        steps(2, 0, 1, 1, 5);
        steps(8, 0, 1, 0, 5);
        check("short_hi_never", hi_cnt, 0);
        check("short_pulse_cnt", sp_cnt, 1);
        check("short_lo_back", pwm_lo, 1);

        // Disable in HI_ON, then re-enable with pwm_in high.
        steps(10, 0, 1, 1, 3);
        step(0, 0, 1, 3);
        check("disable_hi", pwm_hi, 0);
        check("disable_lo", pwm_lo, 0);
        step(0, 0, 1, 3);
        clr();
        steps(8, 0, 1, 1, 3);
        check("reenable_dead", dead_cnt, 3);

        // Reset inside a D=10 fall interval, after dead_time was changed.
        steps(15, 0, 1, 1, 10);
        step(0, 1, 0, 10);
        steps(4, 0, 1, 0, 2);
        step(1, 1, 0, 2);
        check("rst_mid_dead", int'({pwm_hi, pwm_lo, dead_active, short_pulse}), 0);
        steps(4, 0, 1, 0, 2);

        // dead_time changed mid-interval leaves the current interval at 10.
        steps(4, 0, 1, 1, 2);
        steps(6, 0, 1, 1, 10);
        clr();
        step(0, 1, 0, 10);
        steps(3, 0, 1, 0, 1);
        steps(12, 0, 1, 0, 1);
        check("dt_change_dead", dead_cnt, 10);

        // Maximum dead time, no wrap.
        steps(4, 0, 1, 0, 255);
        clr();
        steps(300, 0, 1, 1, 255);
        check("dmax_dead", dead_cnt, 255);
        check("dmax_hi", hi_cnt, 300 - 255);

        // Upstream 8-bit PWM at ontime 128 with D=4.
        up_cnt = 8'd0;
        pin    = 1'b0;
        for (int i = 0; i < 512; i++) begin
            if (i == 256) clr();
            step(0, 1, pin, 4);
            pin    = (up_cnt < 8'd128);
            up_cnt = up_cnt + 8'd1;
        end
        check("pwm128_hi_cycles", hi_cnt, 124);

        // Same generator with random enable drops and resets.
        for (int i = 0; i < 768; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) >= 4), pin, 4);
            pin    = (up_cnt < 8'd128);
            up_cnt = up_cnt + 8'd1;
        end

        // Fully random inputs with short runs of pwm_in.
        for (int i = 0; i < 300; i++) begin
            int run, dt;
            bit en, rst;
            run = $urandom_range(1, 9);
            dt  = $urandom_range(0, 7);
            pin = 1'(($urandom_range(0, 1)));
            en  = ($urandom_range(0, 99) >= 8);
            rst = ($urandom_range(0, 99) < 3);
            step(rst, en, pin, dt);
            steps(run - 1, 0, en, pin, $urandom_range(0, 7));
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
